// File: rtl/spi_reg_bridge_if.sv
// Register-bus handshake between the SPI byte bridge (master) and a register block (slave).
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 4
);
    logic              reg_req_o;
    logic              reg_wr_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [15:0]       reg_data_o;
    logic [15:0]       reg_data_i;
    logic              reg_ack_i;

    modport master (
        output reg_req_o, reg_wr_o, reg_addr_o, reg_data_o,
        input  reg_data_i, reg_ack_i
    );
    modport slave (
        input  reg_req_o, reg_wr_o, reg_addr_o, reg_data_o,
        output reg_data_i, reg_ack_i
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to 16-bit register bus bridge: command/address/data decode plus MISO byte supply.
// Define SPI_BRIDGE_AUTOINC_EN to step the register address after every word.
module spi_reg_bridge #(
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             spi_cs_i,
    input  logic             rx_strobe_i,
    input  logic [7:0]       rx_byte_i,
    input  logic             tx_strobe_i,
    output logic [7:0]       tx_byte_o,
    output logic             err_o,
    spi_reg_bridge_if.master bus
);

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] ADDR_INC = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WR_HI, S_WR_LO, S_RD_TURN, S_RD_HI, S_RD_LO
    } state_t;

    state_t            r_state;
    logic              r_cs_meta, r_cs_sync;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_hi;
    logic [15:0]       r_rd_data;
    logic              r_rd_valid;
    logic              r_req, r_wr;
    logic [ADDR_W-1:0] r_req_addr;
    logic [15:0]       r_wdata;
    logic              r_err;
    logic [7:0]        r_tx;

    logic              w_desel, w_rx, w_ack, w_rd_ack, w_rd_valid, w_busy;
    logic              w_cmd, w_issue_rd, w_issue_wr, w_rd_clr, w_req_nxt, w_err_nxt;
    logic [15:0]       w_rd_data;
    logic [7:0]        w_status;
    logic              w_unused;

    // The SPI target samples tx_byte_o on its own schedule; only rx strobes pace this block.
    assign w_unused   = tx_strobe_i ^ (^rx_byte_i);

    assign w_desel    = r_cs_sync;
    assign w_rx       = rx_strobe_i & ~w_desel;
    assign w_ack      = bus.reg_ack_i & r_req;
    // Acks are folded in before the rx byte is decoded, so same-cycle data is usable.
    assign w_rd_ack   = w_ack & ~r_wr & ~w_desel;
    assign w_rd_valid = r_rd_valid | w_rd_ack;
    assign w_rd_data  = w_rd_ack ? bus.reg_data_i : r_rd_data;
    assign w_busy     = r_req & ~w_ack;
    assign w_cmd      = w_rx & (r_state == S_IDLE);
    assign w_issue_rd = w_rx & ~w_busy &
                        (((r_state == S_IDLE) & rx_byte_i[7]) | (r_state == S_RD_HI));
    assign w_issue_wr = w_rx & ~w_busy & (r_state == S_WR_LO);
    assign w_rd_clr   = w_issue_rd | (w_cmd & rx_byte_i[7]);
    assign w_req_nxt  = w_busy | w_issue_rd | w_issue_wr;

    always_comb begin
        w_err_nxt = r_err;
        if (w_rx) begin
            case (r_state)
                S_IDLE:             w_err_nxt = rx_byte_i[7] & w_busy;
                S_WR_LO:            if (w_busy) w_err_nxt = 1'b1;
                S_RD_TURN, S_RD_LO: if (!w_rd_valid) w_err_nxt = 1'b1;
                S_RD_HI:            if (!w_rd_valid || w_busy) w_err_nxt = 1'b1;
                default:            w_err_nxt = r_err;
            endcase
        end
    end

    // Status reflects the flags as they stand after this cycle's update.
    assign w_status = {4'hA, 2'b00, w_err_nxt, w_req_nxt};

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cs_meta  <= 1'b1;
            r_cs_sync  <= 1'b1;
            r_addr     <= '0;
            r_hi       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_req_addr <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_tx       <= 8'hA0;
        end else begin
            r_cs_meta  <= spi_cs_i;
            r_cs_sync  <= r_cs_meta;
            r_req      <= w_req_nxt;
            r_err      <= w_err_nxt;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_clr ? 1'b0 : w_rd_valid;
            if (w_issue_wr) begin
                r_wr       <= 1'b1;
                r_req_addr <= r_addr;
                r_wdata    <= {r_hi, rx_byte_i};
            end
            if (w_issue_rd) begin
                r_wr       <= 1'b0;
                r_req_addr <= (r_state == S_IDLE) ? rx_byte_i[ADDR_W-1:0] : r_addr + ADDR_INC;
            end
            if (w_desel) begin
                r_state <= S_IDLE;
                r_tx    <= w_status;
            end else if (w_rx) begin
                case (r_state)
                    S_IDLE: begin
                        r_addr  <= rx_byte_i[ADDR_W-1:0];
                        r_tx    <= w_status;
                        r_state <= rx_byte_i[7] ? S_RD_TURN : S_WR_HI;
                    end
                    S_WR_HI: begin
                        r_hi    <= rx_byte_i;
                        r_tx    <= w_status;
                        r_state <= S_WR_LO;
                    end
                    S_WR_LO: begin
                        r_addr  <= r_addr + ADDR_INC;
                        r_tx    <= w_status;
                        r_state <= S_WR_HI;
                    end
                    S_RD_TURN, S_RD_LO: begin
                        r_tx    <= w_rd_valid ? w_rd_data[15:8] : ERR_BYTE;
                        r_state <= S_RD_HI;
                    end
                    S_RD_HI: begin
                        r_tx    <= w_rd_valid ? w_rd_data[7:0] : ERR_BYTE;
                        r_addr  <= r_addr + ADDR_INC;
                        r_state <= S_RD_LO;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_byte_o      = r_tx;
    assign err_o          = r_err;
    assign bus.reg_req_o  = r_req;
    assign bus.reg_wr_o   = r_wr;
    assign bus.reg_addr_o = r_req_addr;
    assign bus.reg_data_o = r_wdata;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized bench for spi_reg_bridge: transaction-level model of MISO bytes and bus traffic.
module tb_spi_reg_bridge;
    localparam int ADDR_W = 4;
    localparam int GAP    = 6;
`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_i, spi_cs_i, rx_strobe_i, tx_strobe_i, err_o;
    logic [7:0] rx_byte_i, tx_byte_o;

    spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    spi_reg_bridge #(.ADDR_W(ADDR_W), .ERR_BYTE(8'hEE)) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .spi_cs_i    (spi_cs_i),
        .rx_strobe_i (rx_strobe_i),
        .rx_byte_i   (rx_byte_i),
        .tx_strobe_i (tx_strobe_i),
        .tx_byte_o   (tx_byte_o),
        .err_o       (err_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] slv_mem [16];
    logic [15:0] ref_mem [16];
    logic [15:0] wbuf [4];
    logic [20:0] obs_q [$];
    logic [20:0] exp_q [$];
    logic [7:0]  miso [$];
    bit          ack_en;
    int          ack_lat;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status(input logic e, input logic r);
        return {4'hA, 2'b00, e, r};
    endfunction

    // Register-block model: acks after ack_lat cycles, logs each completed transfer.
    initial begin : responder
        int cnt;
        cnt = 0;
        bus.reg_ack_i  = 1'b0;
        bus.reg_data_i = 16'h0;
        forever begin
            @(negedge clk);
            bus.reg_ack_i = 1'b0;
            if (bus.reg_req_o && ack_en) begin
                if (cnt >= ack_lat) begin
                    cnt = 0;
                    bus.reg_ack_i = 1'b1;
                    if (bus.reg_wr_o) begin
                        slv_mem[bus.reg_addr_o] = bus.reg_data_o;
                        obs_q.push_back({1'b1, bus.reg_addr_o, bus.reg_data_o});
                    end else begin
                        bus.reg_data_i = slv_mem[bus.reg_addr_o];
                        obs_q.push_back({1'b0, bus.reg_addr_o, 16'h0});
                    end
                end else cnt++;
            end else cnt = 0;
        end
    end

    task automatic spi_byte(input logic [7:0] mosi);
        @(negedge clk);
        tx_strobe_i = 1'b1;
        miso.push_back(tx_byte_o);
        @(negedge clk);
        tx_strobe_i = 1'b0;
        repeat (GAP) @(negedge clk);
        rx_byte_i   = mosi;
        rx_strobe_i = 1'b1;
        @(negedge clk);
        rx_strobe_i = 1'b0;
    endtask

    task automatic sel();
        @(negedge clk);
        spi_cs_i = 1'b0;
        repeat (3) @(negedge clk);
        miso.delete();
    endtask

    task automatic desel();
        @(negedge clk);
        spi_cs_i = 1'b1;
        repeat (GAP + 8) @(negedge clk);
    endtask

    task automatic check_log();
        chk("log_n", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("log_entry", obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_write(input logic [3:0] a, input int n);
        logic [3:0] ad;
        sel();
        spi_byte({1'b0, 3'($urandom), a});
        for (int i = 0; i < n; i++) begin
            spi_byte(wbuf[i][15:8]);
            spi_byte(wbuf[i][7:0]);
        end
        ad = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, ad, wbuf[i]});
            ref_mem[ad] = wbuf[i];
            ad = ad + 4'(INC);
        end
        chk("wr_miso_n", miso.size(), 2 * n + 1);
        chk("wr_status0", miso[0], status(m_err, 1'b0));
        // A completed word leaves its request pending in the status byte that follows it.
        for (int k = 1; k < miso.size(); k++)
            chk("wr_status", miso[k], status(1'b0, (k >= 3) && (k % 2 == 1)));
        chk("wr_err", err_o, 1'b0);
        m_err = 1'b0;
        desel();
        check_log();
    endtask

    task automatic do_read(input logic [3:0] a, input int n);
        logic [3:0] ad;
        sel();
        spi_byte({1'b1, 3'($urandom), a});
        for (int i = 0; i < 2 * n + 1; i++) spi_byte(8'($urandom));
        chk("rd_miso_n", miso.size(), 2 * n + 2);
        chk("rd_status0", miso[0], status(m_err, 1'b0));
        chk("rd_turn", miso[1], status(1'b0, 1'b1));
        ad = a;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                chk("rd_hi", miso[2 + 2 * i], ref_mem[ad][15:8]);
                chk("rd_lo", miso[3 + 2 * i], ref_mem[ad][7:0]);
            end
            exp_q.push_back({1'b0, ad, 16'h0});
            ad = ad + 4'(INC);
        end
        chk("rd_err", err_o, 1'b0);
        m_err = 1'b0;
        desel();
        check_log();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] a;
        reset_i = 1'b1; spi_cs_i = 1'b1; rx_strobe_i = 1'b0; tx_strobe_i = 1'b0;
        rx_byte_i = 8'h0; ack_en = 1'b1; ack_lat = 0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 16'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_byte_o, 8'hA0);
        chk("rst_req", bus.reg_req_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_wr", bus.reg_wr_o, 1'b0);
        chk("rst_addr", bus.reg_addr_o, 4'h0);
        chk("rst_data", bus.reg_data_o, 16'h0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);

        // Write burst
        ack_lat = 1;
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
        do_write(4'h3, 2);

        // Read with ack 3 clocks after req
        ack_lat = 2;
        slv_mem[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;
        do_read(4'h5, 1);

        // Address wrap
        wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
        do_write(4'hF, 2);

        // Ack landing in the same cycle as the next rx byte is still in time
        ack_lat = GAP + 2;
        do_read(4'($urandom), 2);

        // One cycle late: hi byte errors, late data still serves the lo byte
        ack_lat = GAP + 3;
        a = 4'($urandom);
        sel();
        spi_byte({1'b1, 3'b000, a});
        for (int i = 0; i < 3; i++) spi_byte(8'($urandom));
        chk("late_turn", miso[1], status(1'b0, 1'b1));
        chk("late_hi", miso[2], 8'hEE);
        chk("late_lo", miso[3], ref_mem[a][7:0]);
        chk("late_err", err_o, 1'b1);
        desel();
        exp_q.push_back({1'b0, a, 16'h0});
        exp_q.push_back({1'b0, a + 4'(INC), 16'h0});
        check_log();
        m_err = 1'b1;

        // Timeout: ack withheld, req survives deselect
        ack_en = 1'b0; ack_lat = 0;
        sel();
        spi_byte(8'h85);
        spi_byte(8'h00);
        spi_byte(8'h00);
        chk("to_status0", miso[0], status(1'b1, 1'b0));
        chk("to_turn", miso[1], status(1'b0, 1'b1));
        chk("to_err_byte", miso[2], 8'hEE);
        chk("to_err", err_o, 1'b1);
        desel();
        chk("to_req_held", bus.reg_req_o, 1'b1);
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("to_req_drop", bus.reg_req_o, 1'b0);
        exp_q.push_back({1'b0, 4'h5, 16'h0});
        check_log();
        wbuf[0] = 16'($urandom);
        do_write(4'($urandom), 1);

        // Abort mid-write, then a fresh command
        sel();
        spi_byte(8'h03);
        spi_byte(8'h12);
        desel();
        chk("abort_req", bus.reg_req_o, 1'b0);
        check_log();
        wbuf[0] = 16'hABCD;
        do_write(4'h7, 1);

        // Overrun: second word dropped while the first is unacked
        ack_en = 1'b0;
        wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
        sel();
        spi_byte(8'h02);
        spi_byte(wbuf[0][15:8]); spi_byte(wbuf[0][7:0]);
        spi_byte(wbuf[1][15:8]); spi_byte(wbuf[1][7:0]);
        spi_byte(8'h00);
        chk("ovr_s1", miso[1], 8'hA0);
        chk("ovr_s3", miso[3], 8'hA1);
        chk("ovr_s4", miso[4], 8'hA1);
        chk("ovr_s5", miso[5], 8'hA3);
        chk("ovr_err", err_o, 1'b1);
        desel();
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back({1'b1, 4'h2, wbuf[0]});
        ref_mem[2] = wbuf[0];
        check_log();
        m_err = 1'b1;

        // Asynchronous reset with a read pending
        ack_en = 1'b0;
        sel();
        spi_byte(8'h89);
        @(negedge clk);
        chk("rr_req_pre", bus.reg_req_o, 1'b1);
        reset_i = 1'b1;
        #1;
        chk("rr_req", bus.reg_req_o, 1'b0);
        chk("rr_tx", tx_byte_o, 8'hA0);
        chk("rr_err", err_o, 1'b0);
        chk("rr_addr", bus.reg_addr_o, 4'h0);
        @(negedge clk);
        reset_i = 1'b0;
        ack_en = 1'b1;
        m_err = 1'b0;
        desel();
        check_log();

        // Randomized mix within the latency budget
        for (int t = 0; t < 16; t++) begin
            ack_lat = $urandom_range(GAP + 2, 0);
            if ($urandom_range(1, 0) == 1) begin
                do_read(4'($urandom), $urandom_range(3, 1));
            end else begin
                for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
                do_write(4'($urandom), $urandom_range(3, 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
